// File: rtl/ddr_rx.sv
// ddr_rx: iCE40 DDR LVDS receive, deserialises 2 bits/clk into 8-bit words
// aligned by hunting for a repeating training word.
module ddr_rx #(
  parameter logic [7:0] TRAIN_WORD = 8'h05,
  parameter int         LOCK_COUNT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ddr_in_p,
  input  logic       realign,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       locked,
  output logic       align_err,
  output logic       bit_slip
);
  localparam int CW = $clog2(LOCK_COUNT + 1);
  typedef enum logic [1:0] {HUNT, CHECK, LOCK} state_t;
  state_t        state_q, state_d;
  logic          d0, d1;
  logic [15:7]   hist_q;
  logic [1:0]    fill_q, phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    data_q, data_d, w0, w1, ws;
  logic          slip_q, slip_d, valid_q, valid_d, err_q, err_d, locked_q, locked_d;
  logic          bnd, hit0, hit1;
`ifdef SYNTHESIS
  SB_IO #(.PIN_TYPE(6'b000000), .IO_STANDARD("SB_LVDS_INPUT")) pad (
    .PACKAGE_PIN(ddr_in_p),
    .INPUT_CLK  (clk),
    .D_IN_0     (d0),
    .D_IN_1     (d1)
  );
`else
  // Behavioural stand-in for the SB_IO input DDR registers.
  always_ff @(posedge clk) d0 <= ddr_in_p;
  always_ff @(negedge clk) d1 <= ddr_in_p;
`endif
  // Only hist[15:7] is ever read, so the lower history bits are not kept.
  assign w0   = hist_q[15:8];
  assign w1   = hist_q[14:7];
  assign ws   = slip_q ? w1 : w0;
  assign bnd  = phase_q == 2'd3;
  assign hit0 = fill_q == 2'd3 && w0 == TRAIN_WORD;
  assign hit1 = fill_q == 2'd3 && w1 == TRAIN_WORD;
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q + 2'd1;
    cnt_d    = cnt_q;
    slip_d   = slip_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    locked_d = state_q == LOCK && !realign;
    if (realign && state_q != HUNT) begin
      state_d = HUNT;
      cnt_d   = '0;
    end else if (state_q == HUNT) begin
      if (hit0 || hit1) begin
        slip_d  = !hit0;
        phase_d = '0;
        cnt_d   = CW'(1);
        state_d = CHECK;
      end
    end else if (bnd) begin
      if (state_q == LOCK) begin
        data_d  = ws;
        valid_d = 1'b1;
      end else if (ws == TRAIN_WORD) begin
        cnt_d   = cnt_q + CW'(1);
        state_d = cnt_d >= CW'(LOCK_COUNT) ? LOCK : CHECK;
      end else begin
        err_d   = 1'b1;
        cnt_d   = '0;
        state_d = HUNT;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= HUNT;
      hist_q   <= '0;
      fill_q   <= '0;
      phase_q  <= '0;
      cnt_q    <= '0;
      slip_q   <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hist_q   <= {d1, d0, hist_q[15:9]};
      fill_q   <= fill_q + {1'b0, fill_q != 2'd3};
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      slip_q   <= slip_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      locked_q <= locked_d;
    end
  end
  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign locked     = locked_q;
  assign align_err  = err_q;
  assign bit_slip   = slip_q;
endmodule

// File: tb/tb_ddr_rx.sv
// tb_ddr_rx: randomized DDR stream against a bit-queue reference model of the receiver.
module tb_ddr_rx;
  localparam logic [7:0] TW = 8'h05;
  localparam int         LC = 4;
  logic       clk = 1'b0, reset = 1'b1, ddr_in_p = 1'b0, realign = 1'b0;
  logic [7:0] data_out;
  logic       data_valid, locked, align_err, bit_slip;
  ddr_rx #(.TRAIN_WORD(TW), .LOCK_COUNT(LC)) dut (
    .clk(clk), .reset(reset), .ddr_in_p(ddr_in_p), .realign(realign),
    .data_out(data_out), .data_valid(data_valid), .locked(locked),
    .align_err(align_err), .bit_slip(bit_slip)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_err = 0;
  bit txq[$];
  bit rx[$];
  bit [1:0] pend = 2'b00;
  bit chk_en = 1'b0;
  // Model: rx holds received bits in arrival order since reset; words are read straight from it.
  int ecnt = 0, anchor = 0, since = 0, m_state = 0, m_cnt = 0;
  logic [7:0] m_data = '0;
  logic m_valid = 1'b0, m_locked = 1'b0, m_err = 1'b0, m_slip = 1'b0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mword(input int off);
    logic [7:0] w;
    int k;
    w = '0;
    for (int i = 0; i < 8; i++) begin
      k = rx.size() - 8 - off + i;
      if (k >= 0) w[i] = rx[k];
    end
    return w;
  endfunction

  task automatic model_edge();
    logic [7:0] w0, w1, ws;
    bit bnd;
    ecnt++;
    if (reset) begin
      rx.delete();
      since = 0; m_state = 0; m_cnt = 0; m_slip = 0;
      m_data = '0; m_valid = 0; m_locked = 0; m_err = 0;
      return;
    end
    w0 = mword(0);
    w1 = mword(1);
    ws = m_slip ? w1 : w0;
    bnd = m_state != 0 && (ecnt - anchor) % 4 == 0;
    m_valid = 0;
    m_err = 0;
    m_locked = m_state == 2 && !realign;
    if (realign && m_state != 0) begin
      m_state = 0; m_cnt = 0;
    end else if (m_state == 0) begin
      if (since >= 3 && (w0 == TW || w1 == TW)) begin
        m_slip = w0 != TW; anchor = ecnt; m_cnt = 1; m_state = 1;
      end
    end else if (bnd) begin
      if (m_state == 2) begin
        m_data = ws; m_valid = 1;
      end else if (ws == TW) begin
        m_cnt++;
        if (m_cnt >= LC) m_state = 2;
      end else begin
        m_err = 1; m_cnt = 0; m_state = 0;
      end
    end
    rx.push_back(pend[0]);
    rx.push_back(pend[1]);
    while (rx.size() > 32) void'(rx.pop_front());
    since++;
  endtask

  task automatic push_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) txq.push_back(w[i]);
  endtask

  // One clock: b0 is captured on the rising edge, b1 on the falling edge.
  task automatic tick();
    bit b0, b1;
    if (txq.size() < 2) push_word(TW);
    b0 = txq.pop_front();
    b1 = txq.pop_front();
    ddr_in_p = b0;
    @(posedge clk);
    #1;
    model_edge();
    pend = {b1, b0};
    ddr_in_p = b1;
    @(negedge clk);
    #1;
  endtask

  task automatic setup(input int d);
    reset = 1'b1;
    txq.delete();
    for (int i = 0; i < d; i++) txq.push_back(1'b0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("data_out", data_out, m_data);
      chk("data_valid", {7'b0, data_valid}, {7'b0, m_valid});
      chk("locked", {7'b0, locked}, {7'b0, m_locked});
      chk("align_err", {7'b0, align_err}, {7'b0, m_err});
      chk("bit_slip", {7'b0, bit_slip}, {7'b0, m_slip});
    end
  end

  initial begin
    int errs, nv;
    bit lock_at_err, lost, found;
    logic [7:0] got[$];
    logic [7:0] r;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst data_out", data_out, 8'h00);
    chk("rst data_valid", {7'b0, data_valid}, 8'h00);
    chk("rst locked", {7'b0, locked}, 8'h00);
    chk("rst align_err", {7'b0, align_err}, 8'h00);
    chk("rst bit_slip", {7'b0, bit_slip}, 8'h00);
    for (int d = 0; d < 8; d++) begin
      setup(d);
      for (int i = 0; i < 120 && !locked; i++) tick();
      chk("offset lock", {7'b0, locked}, 8'h01);
      chk("offset slip", {7'b0, bit_slip}, 8'(d % 2));
      for (int i = 0; i < 8 && !data_valid; i++) tick();
      chk("offset valid", {7'b0, data_valid}, 8'h01);
      chk("offset word", data_out, 8'h05);
    end
    setup(3);
    for (int i = 0; i < 120 && m_state != 1; i++) tick();
    push_word(8'h07);
    errs = 0;
    lock_at_err = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (align_err) begin
        errs++;
        if (locked) lock_at_err = 1;
      end
    end
    chk("corrupt err pulses", 8'(errs), 8'h01);
    chk("corrupt locked at err", {7'b0, lock_at_err}, 8'h00);
    chk("corrupt relock", {7'b0, locked}, 8'h01);
    push_word(8'hA3);
    push_word(8'h3C);
    push_word(8'hFF);
    push_word(8'h00);
    errs = 0;
    lost = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (data_valid) got.push_back(data_out);
      if (!locked) lost = 1;
      if (align_err) errs++;
    end
    found = 0;
    for (int i = 0; i + 3 < got.size(); i++)
      if (got[i] == 8'hA3 && got[i+1] == 8'h3C && got[i+2] == 8'hFF && got[i+3] == 8'h00) found = 1;
    chk("payload sequence", {7'b0, found}, 8'h01);
    chk("payload lock kept", {7'b0, lost}, 8'h00);
    chk("payload no err", 8'(errs), 8'h00);
    realign = 1'b1;
    tick();
    realign = 1'b0;
    chk("realign drop", {7'b0, locked}, 8'h00);
    nv = 0;
    for (int i = 0; i < 100 && !locked; i++) begin
      tick();
      if (data_valid) nv++;
    end
    chk("realign no valid", 8'(nv), 8'h00);
    chk("realign relock", {7'b0, locked}, 8'h01);
    chk("realign slip", {7'b0, bit_slip}, 8'h01);
    for (int i = 0; i < 8 && !data_valid; i++) tick();
    chk("locked word", data_out, 8'h05);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst locked data", data_out, 8'h00);
    chk("rst locked lock", {7'b0, locked}, 8'h00);
    chk("rst locked slip", {7'b0, bit_slip}, 8'h00);
    for (int i = 0; i < 120 && m_state != 1; i++) tick();
    chk("check slip", {7'b0, bit_slip}, 8'h01);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst check slip", {7'b0, bit_slip}, 8'h00);
    chk("rst check valid", {7'b0, data_valid}, 8'h00);
    for (int i = 0; i < 120 && !locked; i++) tick();
    chk("post rst relock", {7'b0, locked}, 8'h01);
    for (int i = 0; i < 800; i++) begin
      realign = $urandom_range(59) == 0;
      reset = $urandom_range(299) == 0;
      if (txq.size() < 2) begin
        r = 8'($urandom_range(9));
        if (r < 6) push_word(TW);
        else if (r < 9) push_word(8'($urandom));
        else begin
          txq.push_back(1'($urandom));
          push_word(TW);
        end
      end
      tick();
    end
    reset = 1'b0;
    realign = 1'b0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
